// File: rtl/riscv_fetch_pkg.sv
// ---------------------------------------------------------------------------
// riscv_fetch_pkg
// Shared definitions for the instruction fetch sequencer and its queue.
//   fetch_state_e : sequencer states (TRAP is only reachable when the
//                   FETCH_MISALIGN_TRAP_EN macro is defined)
//   XLEN          : default PC width
//   RESET_PC      : default PC loaded on reset
//   INSTR_W       : instruction word width
//   PC_INC        : byte increment between sequential fetches
// ---------------------------------------------------------------------------
package riscv_fetch_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      TRAP = 2'd3
   } fetch_state_e;

   localparam int          XLEN     = 64;
   localparam logic [63:0] RESET_PC = 64'h0;
   localparam int          INSTR_W  = 32;
   localparam int          PC_INC   = 4;

endpackage

// File: rtl/fetch_instr_queue.sv
// ---------------------------------------------------------------------------
// fetch_instr_queue
// Small FIFO of {instruction, pc} pairs sitting between the fetch sequencer
// and decode. Push and pop in the same cycle are both honoured; flush empties
// the queue and wins over push and pop. The head is read combinationally from
// storage, so a push into an empty queue shows up one cycle later. The head
// outputs read as zero while the queue is empty.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   flush           discard all entries
//   push            write push_instr/push_pc at the tail (caller guarantees
//                   the queue is not full)
//   pop             remove the head (ignored when empty)
//   head_valid      queue not empty
//   head_instr      head instruction word
//   head_pc         PC of head instruction
//   count           number of stored entries
// ---------------------------------------------------------------------------
module fetch_instr_queue
   import riscv_fetch_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int PC_W  = 64,
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               flush,
   input  logic               push,
   input  logic [INSTR_W-1:0] push_instr,
   input  logic [PC_W-1:0]    push_pc,
   input  logic               pop,
   output logic               head_valid,
   output logic [INSTR_W-1:0] head_instr,
   output logic [PC_W-1:0]    head_pc,
   output logic [CNT_W-1:0]   count
);

   logic [INSTR_W-1:0] instr_mem [DEPTH];
   logic [PC_W-1:0]    pc_mem    [DEPTH];
   logic [PTR_W-1:0]   rd_ptr;
   logic [PTR_W-1:0]   wr_ptr;
   logic               do_push;
   logic               do_pop;

   assign do_push = push & ~flush;
   assign do_pop  = pop & ~flush & (count != '0);

   // Entry storage needs no reset; validity is tracked by count alone.
   always_ff @(posedge clk) begin
      if (do_push) begin
         instr_mem[wr_ptr] <= push_instr;
         pc_mem[wr_ptr]    <= push_pc;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   assign head_valid = (count != '0);
   assign head_instr = head_valid ? instr_mem[rd_ptr] : '0;
   assign head_pc    = head_valid ? pc_mem[rd_ptr]    : '0;

endmodule

// File: rtl/fetch_ctrl_riscv.sv
// ---------------------------------------------------------------------------
// fetch_ctrl_riscv
// Fetch sequencer between the PC logic and a multi-cycle instruction memory.
// Owns the PC, keeps at most one word request outstanding, buffers returned
// words in fetch_instr_queue for decode, and applies branch redirects by
// flushing the queue and discarding any in-flight response.
//
// Optional build macro: FETCH_MISALIGN_TRAP_EN
//   defined   : a redirect to a non word-aligned target parks the fetcher in
//               TRAP (no requests, fetch_misalign=1) until an aligned redirect
//               or reset.
//   undefined : branch_pc[1:0] are cleared before loading the PC.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   branch_en         one-cycle redirect strobe
//   branch_pc         redirect target
//   imem_req_valid    request valid toward memory
//   imem_req_ready    memory accepts the request
//   imem_req_addr     byte address of requested word
//   imem_resp_valid   response strobe (one per accepted request)
//   imem_resp_data    returned instruction word
//   instr_valid       queue head valid toward decode
//   instr_ready       decode consumes head
//   instr             head instruction
//   instr_pc          PC of head instruction
//   fetch_misalign    (macro only) misaligned-redirect trap indicator
// ---------------------------------------------------------------------------
module fetch_ctrl_riscv #(
   parameter int              XLEN     = riscv_fetch_pkg::XLEN,
   parameter logic [XLEN-1:0] RESET_PC = XLEN'(riscv_fetch_pkg::RESET_PC),
   parameter int              QDEPTH   = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            branch_en,
   input  logic [XLEN-1:0] branch_pc,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_resp_valid,
   input  logic [31:0]     imem_resp_data,
   output logic            instr_valid,
   input  logic            instr_ready,
   output logic [31:0]     instr,
   output logic [XLEN-1:0] instr_pc
`ifdef FETCH_MISALIGN_TRAP_EN
   ,
   output logic            fetch_misalign
`endif
);

   import riscv_fetch_pkg::*;

   localparam int CNT_W = $clog2(QDEPTH + 1);

   fetch_state_e    state;
   fetch_state_e    state_next;
   logic [XLEN-1:0] pc;
   logic [XLEN-1:0] pc_next;
   logic [XLEN-1:0] req_pc;
   logic [XLEN-1:0] req_pc_next;
   logic [XLEN-1:0] target_pc;
   logic            drop;
   logic            drop_next;
   logic            misaligned;
   logic            has_credit;
   logic            req_fire;
   logic            q_push;
   logic            q_pop;
   logic            q_flush;
   logic            q_valid;
   logic [CNT_W-1:0] q_count;

`ifdef FETCH_MISALIGN_TRAP_EN
   assign target_pc      = branch_pc;
   assign misaligned     = (branch_pc[1:0] != 2'b00);
   assign fetch_misalign = (state == TRAP);
`else
   assign target_pc  = branch_pc & ~XLEN'(3);
   assign misaligned = 1'b0;
`endif

   // Requests are only made from REQ, where nothing is outstanding, so the
   // free-slot credit reduces to the queue's own free space.
   assign has_credit     = (q_count < CNT_W'(QDEPTH));
   assign imem_req_valid = (state == REQ) && has_credit;
   assign imem_req_addr  = pc;
   assign req_fire       = imem_req_valid & imem_req_ready;

   // A redirect flushes the queue, so a pop in that same cycle is meaningless.
   assign q_pop = q_valid & instr_ready & ~branch_en;

   fetch_instr_queue #(
      .DEPTH (QDEPTH),
      .PC_W  (XLEN)
   ) u_queue (
      .clk        (clk),
      .rst        (rst),
      .flush      (q_flush),
      .push       (q_push),
      .push_instr (imem_resp_data),
      .push_pc    (req_pc),
      .pop        (q_pop),
      .head_valid (q_valid),
      .head_instr (instr),
      .head_pc    (instr_pc),
      .count      (q_count)
   );

   assign instr_valid = q_valid;

   // Sequencer state register. req_pc remembers the address of the request
   // in flight so its response can be tagged when it returns.
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         pc     <= RESET_PC;
         req_pc <= '0;
         drop   <= 1'b0;
      end else begin
         state  <= state_next;
         pc     <= pc_next;
         req_pc <= req_pc_next;
         drop   <= drop_next;
      end
   end

   // Next-state logic. Normal sequencing is resolved first, then a redirect
   // overrides it. drop marks a request that was in flight across a redirect;
   // its response must be swallowed rather than enqueued.
   always_comb begin
      state_next  = state;
      pc_next     = pc;
      req_pc_next = req_pc;
      drop_next   = drop;
      q_push      = 1'b0;
      q_flush     = 1'b0;

      case (state)
         IDLE: state_next = REQ;
         REQ: begin
            if (req_fire) begin
               state_next  = WAIT;
               req_pc_next = pc;
               pc_next     = pc + XLEN'(PC_INC);
            end
         end
         WAIT: begin
            if (imem_resp_valid) begin
               q_push     = ~drop;
               state_next = REQ;
               drop_next  = 1'b0;
            end
         end
         default: ;
      endcase

      if (branch_en) begin
         q_flush = 1'b1;
         q_push  = 1'b0;
         if (misaligned) begin
            state_next = TRAP;
            drop_next  = 1'b0;
         end else begin
            pc_next = target_pc;
            if ((state == REQ) && req_fire) begin
               drop_next = 1'b1;
            end
            if ((state == WAIT) && !imem_resp_valid) begin
               drop_next = 1'b1;
            end
            if (state == TRAP) begin
               state_next = REQ;
            end
         end
      end
   end

endmodule

// File: tb/tb_fetch_ctrl_riscv.sv
// ---------------------------------------------------------------------------
// tb_fetch_ctrl_riscv
// Self-checking bench for fetch_ctrl_riscv. A behavioural memory answers each
// accepted request after a random latency, and a transaction-level model
// tracks which words decode should see: sequential words from the current
// fetch target, with any word whose request straddled a redirect thrown away.
// Honour FETCH_MISALIGN_TRAP_EN the same way as the design.
// ---------------------------------------------------------------------------
module tb_fetch_ctrl_riscv;

   localparam int          QDEPTH   = 2;
   localparam logic [63:0] RESET_PC = 64'h0;

   typedef struct {
      logic [31:0] data;
      logic [63:0] pc;
   } entry_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        branch_en = 1'b0;
   logic [63:0] branch_pc = '0;
   logic        imem_req_valid;
   logic        imem_req_ready = 1'b0;
   logic [63:0] imem_req_addr;
   logic        imem_resp_valid = 1'b0;
   logic [31:0] imem_resp_data = '0;
   logic        instr_valid;
   logic        instr_ready = 1'b0;
   logic [31:0] instr;
   logic [63:0] instr_pc;
`ifdef FETCH_MISALIGN_TRAP_EN
   logic        fetch_misalign;
`endif

   // Model state
   entry_t      mq[$];
   logic [63:0] expFetch;
   bit          awaiting;
   bit          idle;
   bit          trapped;
   bit          pending;
   bit          stale;
   int          due;
   logic [63:0] paddr;
   int          tcyc;
   int          sinceReset;
   int          firstValid;
   int          checkCount = 0;
   int          passCount  = 0;

   always #5 clk = ~clk;

   fetch_ctrl_riscv #(
      .XLEN     (64),
      .RESET_PC (RESET_PC),
      .QDEPTH   (QDEPTH)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .branch_en       (branch_en),
      .branch_pc       (branch_pc),
      .imem_req_valid  (imem_req_valid),
      .imem_req_ready  (imem_req_ready),
      .imem_req_addr   (imem_req_addr),
      .imem_resp_valid (imem_resp_valid),
      .imem_resp_data  (imem_resp_data),
      .instr_valid     (instr_valid),
      .instr_ready     (instr_ready),
      .instr           (instr),
      .instr_pc        (instr_pc)
`ifdef FETCH_MISALIGN_TRAP_EN
      ,
      .fetch_misalign  (fetch_misalign)
`endif
   );

   // Contents of instruction memory: an address hash so every word differs.
   function automatic logic [31:0] memWord(input logic [63:0] a);
      return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h1357_9BDF;
   endfunction

   function automatic logic [63:0] randTarget();
      logic [63:0] t;
      if ($urandom_range(0, 3) == 0) t = {$urandom, $urandom};
      else                           t = 64'($urandom_range(0, 4095));
      if ($urandom_range(0, 3) != 0) t = t & ~64'h3;
      return t;
   endfunction

   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checkCount++;
      if (got === exp) passCount++;
      else $display("[TB] FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
   endtask

   // Redirect as seen from the outside: sequential fetch restarts at target.
   task automatic modelBranch(input logic [63:0] t);
      mq.delete();
      if (pending) stale = 1;
`ifdef FETCH_MISALIGN_TRAP_EN
      if (t[1:0] != 2'b00) begin
         trapped  = 1;
         awaiting = 0;
      end else begin
         trapped  = 0;
         expFetch = t;
      end
`else
      expFetch = t & ~64'h3;
`endif
   endtask

   task automatic applyReset();
      @(negedge clk);
      rst = 1'b1;
      branch_en = 1'b0;
      imem_req_ready = 1'b0;
      imem_resp_valid = 1'b0;
      instr_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkOutput("rst_req_valid", 64'(imem_req_valid), 64'd0);
      checkOutput("rst_instr_valid", 64'(instr_valid), 64'd0);
      checkOutput("rst_instr", 64'(instr), 64'd0);
      checkOutput("rst_instr_pc", instr_pc, 64'd0);
`ifdef FETCH_MISALIGN_TRAP_EN
      checkOutput("rst_misalign", 64'(fetch_misalign), 64'd0);
`endif
      mq.delete();
      awaiting   = 0;
      idle       = 1;
      trapped    = 0;
      stale      = 1;
      expFetch   = RESET_PC;
      sinceReset = 0;
      firstValid = -1;
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   // One iteration per clock: check outputs against the model, drive the
   // memory/decode/redirect inputs, then advance the model over the edge.
   // mode 0: random redirects (pBranch %), 1: one redirect while a request
   // waits with no response, 2: one redirect together with the response,
   // 3: one redirect at iteration branchAt.
   task automatic applyStimulus(input int n, input int pBranch, input int pReady,
                                input int pInstr, input int latMin, input int latMax,
                                input int mode, input int branchAt, input logic [63:0] tgt);
      bit done;
      done = 0;
      for (int i = 0; i < n; i++) begin
         bit          expValid;
         bit          resp;
         bit          rdy;
         bit          ird;
         bit          br;
         bit          fire;
         logic [63:0] t;
         @(negedge clk);
         expValid = !idle && !awaiting && !trapped && (mq.size() < QDEPTH);
         checkOutput("req_valid", 64'(imem_req_valid), 64'(expValid));
         if (expValid) checkOutput("req_addr", imem_req_addr, expFetch);
         checkOutput("instr_valid", 64'(instr_valid), 64'(mq.size() != 0));
         if (mq.size() != 0) begin
            checkOutput("instr", 64'(instr), 64'(mq[0].data));
            checkOutput("instr_pc", instr_pc, mq[0].pc);
         end
`ifdef FETCH_MISALIGN_TRAP_EN
         checkOutput("fetch_misalign", 64'(fetch_misalign), 64'(trapped));
`endif
         if (instr_valid && firstValid < 0) firstValid = sinceReset;

         resp = pending && (due == tcyc);
         rdy  = !pending && ($urandom_range(0, 99) < pReady);
         ird  = ($urandom_range(0, 99) < pInstr);
         t    = tgt;
         case (mode)
            0: begin
               br = ($urandom_range(0, 99) < pBranch);
               t  = randTarget();
            end
            1:       br = !done && awaiting && !resp;
            2:       br = !done && awaiting && resp;
            default: br = !done && (i == branchAt);
         endcase
         if (br) done = 1;

         imem_req_ready  = rdy;
         imem_resp_valid = resp;
         imem_resp_data  = resp ? memWord(paddr) : $urandom;
         instr_ready     = ird;
         branch_en       = br;
         branch_pc       = br ? t : {$urandom, $urandom};
         #1;

         fire = expValid && rdy;
         if ((mq.size() != 0) && ird && !br) void'(mq.pop_front());
         if (resp) begin
            pending = 0;
            if (awaiting) begin
               awaiting = 0;
               if (!stale && !br) mq.push_back('{data: memWord(paddr), pc: paddr});
            end
         end
         if (fire) begin
            awaiting = 1;
            pending  = 1;
            stale    = 0;
            paddr    = expFetch;
            due      = tcyc + int'($urandom_range(latMin, latMax));
            expFetch = expFetch + 64'd4;
         end
         if (br) modelBranch(t);
         idle = 0;
         tcyc++;
         sinceReset++;
      end
   endtask

   initial begin
      tcyc    = 0;
      pending = 0;
      paddr   = '0;
      due     = 0;

      // Sequential fetch, latency 1, decode always ready.
      applyReset();
      applyStimulus(14, 0, 100, 100, 1, 1, 0, 0, 64'h0);
      checkOutput("first_valid_delay", 64'(firstValid), 64'd3);

      // Decode stalled: queue fills to QDEPTH and requests stop, then drain.
      applyReset();
      applyStimulus(12, 0, 100, 0, 1, 1, 0, 0, 64'h0);
      checkOutput("full_no_req", 64'(imem_req_valid), 64'd0);
      checkOutput("full_head_pc", instr_pc, 64'h0);
      applyStimulus(12, 0, 100, 100, 1, 1, 0, 0, 64'h0);

      // Redirect while waiting (latency 3), then together with the response.
      applyStimulus(20, 0, 100, 100, 3, 3, 1, 0, 64'h40);
      applyStimulus(20, 0, 100, 100, 3, 3, 2, 0, 64'h80);

      // Memory not ready for 4 cycles, then retarget the pending request.
      applyReset();
      applyStimulus(5, 0, 0, 100, 1, 1, 3, 4, 64'h100);
      @(posedge clk);
      #1;
      checkOutput("retarget_valid", 64'(imem_req_valid), 64'd1);
      checkOutput("retarget_addr", imem_req_addr, 64'h100);
      applyStimulus(10, 0, 100, 100, 1, 1, 0, 0, 64'h0);

      // PC wraps silently past the top of the address space.
      applyStimulus(20, 0, 100, 100, 1, 2, 3, 1, 64'hFFFF_FFFF_FFFF_FFF4);

`ifdef FETCH_MISALIGN_TRAP_EN
      applyReset();
      applyStimulus(6, 0, 100, 100, 1, 1, 3, 3, 64'h102);
      @(posedge clk);
      #1;
      checkOutput("trap_flag", 64'(fetch_misalign), 64'd1);
      checkOutput("trap_no_req", 64'(imem_req_valid), 64'd0);
      applyStimulus(8, 0, 100, 100, 1, 1, 3, 0, 64'h200);
`endif

      // Random traffic with mid-run resets while requests may be in flight.
      for (int r = 0; r < 3; r++) begin
         applyStimulus(1500, 4, 70, 60, 1, 4, 0, 0, 64'h0);
         applyReset();
      end
      applyStimulus(300, 4, 70, 60, 1, 4, 0, 0, 64'h0);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule

// File: doc/fetch_ctrl_riscv.md
Name: fetch_ctrl_riscv

Overview:
Fetch sequencer between the PC logic and a multi-cycle instruction memory. It owns the 64-bit PC, issues one word request at a time over a valid/ready interface, and buffers returned instructions in a small queue feeding decode. It applies branch redirects by flushing the queue and discarding any in-flight response. It replaces the free-running PC+4 register and combinational memory lookup used in the single-cycle datapath.

Parameters:
RESET_PC, 64'h0, PC value loaded on reset.
QDEPTH, 2, instruction queue entries (power of 2, >=2).
XLEN, 64, PC width.

Ports:
clk  in  1  clock, all state updates on posedge
rst  in  1  synchronous active-high reset
branch_en  in  1  redirect strobe, one-cycle pulse
branch_pc  in  XLEN  redirect target (signed PC)
imem_req_valid  out  1  request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  XLEN  byte address of the 32-bit word
imem_resp_valid  in  1  response strobe, at most one per accepted request, >=1 cycle after accept
imem_resp_data  in  32  instruction word, little-endian
instr_valid  out  1  queue head valid
instr_ready  in  1  decode consumes head
instr  out  32  head instruction
instr_pc  out  XLEN  PC of head instruction

Behaviour:
- Reset: pc=RESET_PC, queue empty, state=IDLE, drop=0; imem_req_valid=0, instr_valid=0, instr=0, instr_pc=0.
- States: IDLE, REQ, WAIT.
  - IDLE -> REQ: the cycle after reset deasserts.
  - REQ: imem_req_valid=1 iff queue free slots >=1 (credit = QDEPTH - count - outstanding). imem_req_addr=pc. On valid&ready -> WAIT; pc<=pc+4.
  - WAIT: on imem_resp_valid, enqueue {data, pc_of_req} unless drop=1; then -> REQ and drop<=0.
- At most one outstanding request. Request latency: the earliest issue is 1 cycle after reset; back-to-back throughput is 1 instruction per (memory latency + 1) cycles.
- Queue: FIFO, depth QDEPTH. Head is presented combinationally from storage; pop on instr_valid&instr_ready. Enqueue and pop in the same cycle are both honoured. Credit accounting guarantees no enqueue when full. A push into an empty queue becomes visible the next cycle; there is no bypass.
- pc arithmetic: modulo 2^XLEN; wrap from all-ones minus 3 to 0 is silent.
- Redirect (branch_en=1), highest priority:
  - pc<=branch_pc; queue flushed (count=0, instr_valid=0 next cycle); any pop that cycle is ignored.
  - If in WAIT with no response that cycle: drop<=1, stay WAIT. When the response arrives, discard it and go to REQ.
  - If in WAIT and the response arrives in the same cycle: discard it, go to REQ.
  - If in REQ and the request is accepted in the same cycle: the request counts as stale; go to WAIT with drop=1, pc=branch_pc.
  - If in REQ and not accepted: stay REQ; imem_req_addr=branch_pc the next cycle. The memory samples only on valid&ready, so retargeting is legal.
- Reset mid-operation overrides all of the above. A response arriving after reset, while a request was outstanding, is ignored: IDLE/REQ ignore imem_resp_valid.
- imem_req_valid, once high with ready low, stays high (the address may change only via redirect).

Optional Feature:
FETCH_MISALIGN_TRAP_EN
- Defined:
  - Adds output fetch_misalign (1 bit).
  - A redirect whose branch_pc[1:0]!=0 enters state TRAP: no requests issued, queue flushed, fetch_misalign=1 held.
  - Only rst or a subsequent aligned redirect leaves TRAP (-> REQ). fetch_misalign resets to 0.
- Undefined: branch_pc[1:0] are forced to 0 before loading pc. There is no port and no TRAP state.

Decomposition:
- Shared package riscv_fetch_pkg: state enum (IDLE, REQ, WAIT, TRAP), XLEN, RESET_PC default, INSTR_W=32, PC_INC=4.
- One sub-module: fetch_instr_queue, a parameterised FIFO of {instr, pc} with push/pop/flush, count output, and simultaneous push/pop.

Test Plan:
- Reset, memory latency 1, instr_ready=1 -> requests at addresses 0,4,8,C; instr_pc matches; first instr_valid 3 cycles after rst deassert.
- instr_ready=0 with QDEPTH=2 -> exactly 2 entries fill and imem_req_valid stays 0. Raise instr_ready -> heads drain in order 0 then 4 and fetch resumes at 8.
- branch_en with branch_pc=0x40 while in WAIT (latency 3) -> stale response discarded; next request addr 0x40; the queue never shows the stale word.
- branch_en in the same cycle as imem_resp_valid -> response dropped, queue empty next cycle, request to target on the following cycle.
- imem_req_ready held 0 for 4 cycles, then redirect to 0x100 -> valid stays high and the address switches to 0x100; the accept then fetches 0x100.
- With FETCH_MISALIGN_TRAP_EN, redirect to 0x102 -> fetch_misalign=1, no requests; redirect to 0x200 -> fetch_misalign=0, request 0x200.
